lsu_ctrl: RTL and testbench

Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address, together with rs2 store data and funct3. It drives a req/ack data-memory port, applies byte lanes and write masks, and returns sign- or zero-extended load data to writeback. The core holds its PC and stalls while o_lsu_busy=1.

---
 rtl/lsu_ctrl_pkg.sv | 28 ++
 rtl/lsu_lane.sv | 51 +++++
 rtl/lsu_ctrl.sv | 155 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared load/store definitions: funct3 access codes, LSU FSM states, funct3 legality.
// Pure definitions; no latency or backpressure.
package lsu_ctrl_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   // Unsigned widths only make sense for loads.
   function automatic logic lsu_f3_legal(input logic [2:0] f3, input logic wren);
      logic ok;
      case (f3)
         LSU_B, LSU_H, LSU_W: ok = 1'b1;
         LSU_BU, LSU_HU:      ok = ~wren;
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store mask/replication, load extraction/extension, alignment check.
// Purely combinational, zero latency; no backpressure.
module lsu_lane
   import lsu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       funct3_i,
   input  logic [1:0]       off_i,
   input  logic [WIDTH-1:0] st_data_i,
   input  logic [WIDTH-1:0] rdata_i,
   output logic [3:0]       bmask_o,
   output logic [WIDTH-1:0] wdata_o,
   output logic [WIDTH-1:0] ld_data_o,
   output logic             misalign_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = rdata_i[{off_i, 3'b000} +: 8];
      half_sel   = rdata_i[{off_i[1], 4'b0000} +: 16];
      bmask_o    = 4'b0000;
      wdata_o    = st_data_i;
      ld_data_o  = '0;
      misalign_o = 1'b0;
      case (funct3_i)
         LSU_B, LSU_BU: begin
            bmask_o   = 4'b0001 << off_i;
            wdata_o   = {(WIDTH/8){st_data_i[7:0]}};
            ld_data_o = (funct3_i == LSU_B) ? {{(WIDTH-8){byte_sel[7]}}, byte_sel}
                                            : {{(WIDTH-8){1'b0}}, byte_sel};
         end
         LSU_H, LSU_HU: begin
            bmask_o    = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o    = {(WIDTH/16){st_data_i[15:0]}};
            ld_data_o  = (funct3_i == LSU_H) ? {{(WIDTH-16){half_sel[15]}}, half_sel}
                                             : {{(WIDTH-16){1'b0}}, half_sel};
            misalign_o = off_i[0];
         end
         LSU_W: begin
            bmask_o    = 4'b1111;
            ld_data_o  = rdata_i;
            misalign_o = (off_i != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: req/ack data-memory master with timeout, lane steering and load extension.
// vld->done 3 cycles on zero-wait ack (2 if rejected); holds REQ until ack, core stalls on busy.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_lsu_vld,
   input  logic             i_lsu_wren,
   input  logic [2:0]       i_funct3,
   input  logic [WIDTH-1:0] i_addr,
   input  logic [WIDTH-1:0] i_st_data,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic [WIDTH-1:0] o_mem_addr,
   output logic [WIDTH-1:0] o_mem_wdata,
   output logic [3:0]       o_mem_bmask,
   input  logic             i_mem_ack,
   input  logic [WIDTH-1:0] i_mem_rdata,
   output logic [WIDTH-1:0] o_ld_data,
   output logic             o_lsu_done,
   output logic             o_lsu_busy,
   output logic             o_misalign,
   output logic             o_bus_err,
   output logic             o_insn_vld
);

   localparam int            CW     = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

   lsu_state_e       state_q;
   logic             wren_q;
   logic [2:0]       funct3_q;
   logic [1:0]       off_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;

   logic             mem_req_q, mem_we_q;
   logic [WIDTH-1:0] mem_addr_q, mem_wdata_q, ld_data_q;
   logic [3:0]       mem_bmask_q;
   logic             done_q, misalign_q, bus_err_q, insn_vld_q;

   logic [2:0]       lane_f3;
   logic [1:0]       lane_off;
   logic [3:0]       lane_bmask;
   logic [WIDTH-1:0] lane_wdata, lane_ld;
   logic             lane_misalign;

   // The lane steers the live request in IDLE and the latched one while waiting for ack.
   assign lane_f3  = (state_q == IDLE) ? i_funct3    : funct3_q;
   assign lane_off = (state_q == IDLE) ? i_addr[1:0] : off_q;
   assign cnt_d    = cnt_q + CW'(1);

   lsu_lane #(.WIDTH(WIDTH)) u_lane (
      .funct3_i   (lane_f3),
      .off_i      (lane_off),
      .st_data_i  (i_st_data),
      .rdata_i    (i_mem_rdata),
      .bmask_o    (lane_bmask),
      .wdata_o    (lane_wdata),
      .ld_data_o  (lane_ld),
      .misalign_o (lane_misalign)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         wren_q      <= 1'b0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_bmask_q <= 4'b0000;
         ld_data_q   <= '0;
         done_q      <= 1'b0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         insn_vld_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (i_lsu_vld) begin
                  wren_q   <= i_lsu_wren;
                  funct3_q <= i_funct3;
                  off_q    <= i_addr[1:0];
                  if (!lsu_f3_legal(i_funct3, i_lsu_wren)) begin
                     state_q    <= RESP;
                     done_q     <= 1'b1;
                     insn_vld_q <= 1'b0;
                     ld_data_q  <= '0;
                  end else if (lane_misalign) begin
                     state_q    <= RESP;
                     done_q     <= 1'b1;
                     insn_vld_q <= 1'b1;
                     misalign_q <= 1'b1;
                     ld_data_q  <= '0;
                  end else begin
                     state_q     <= REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= i_lsu_wren;
                     mem_addr_q  <= {i_addr[WIDTH-1:2], 2'b00};
                     mem_wdata_q <= lane_wdata;
                     mem_bmask_q <= lane_bmask;
                  end
               end
            end
            REQ: begin
               cnt_q <= cnt_d;
               // An ack on the final allowed cycle still wins over the timeout.
               if (i_mem_ack || (cnt_d == TO_CNT)) begin
                  state_q     <= RESP;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_bmask_q <= 4'b0000;
                  done_q      <= 1'b1;
                  insn_vld_q  <= 1'b1;
                  bus_err_q   <= ~i_mem_ack;
                  ld_data_q   <= (i_mem_ack && !wren_q) ? lane_ld : '0;
               end
            end
            RESP: begin
               state_q    <= IDLE;
               cnt_q      <= '0;
               done_q     <= 1'b0;
               insn_vld_q <= 1'b0;
               misalign_q <= 1'b0;
               bus_err_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_mem_req   = mem_req_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_mem_bmask = mem_bmask_q;
   assign o_ld_data   = ld_data_q;
   assign o_lsu_done  = done_q;
   assign o_lsu_busy  = (state_q != IDLE);
   assign o_misalign  = misalign_q;
   assign o_bus_err   = bus_err_q;
   assign o_insn_vld  = insn_vld_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: expected requests/responses queued at issue, checked by a negedge monitor.
module tb_lsu_ctrl;
   import lsu_ctrl_pkg::*;

   localparam int TO = 16;

   logic        clk;
   logic        i_rst_n;
   logic        i_lsu_vld, i_lsu_wren, i_mem_ack;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr, i_st_data, i_mem_rdata;
   logic        o_mem_req, o_mem_we, o_lsu_done, o_lsu_busy, o_misalign, o_bus_err, o_insn_vld;
   logic [31:0] o_mem_addr, o_mem_wdata, o_ld_data;
   logic [3:0]  o_mem_bmask;

   lsu_ctrl #(.WIDTH(32), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst_n(i_rst_n), .i_lsu_vld(i_lsu_vld), .i_lsu_wren(i_lsu_wren),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask), .i_mem_ack(i_mem_ack),
      .i_mem_rdata(i_mem_rdata), .o_ld_data(o_ld_data), .o_lsu_done(o_lsu_done),
      .o_lsu_busy(o_lsu_busy), .o_misalign(o_misalign), .o_bus_err(o_bus_err),
      .o_insn_vld(o_insn_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  bmask;
      int          len;
   } req_t;

   typedef struct {
      logic [31:0] ld;
      bit          chk_ld;
      logic        mis;
      logic        berr;
      logic        ivld;
      int          done_cyc;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   req_t cur;
   rsp_t r;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   in_req = 0;
   int   rlen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (o_mem_req) begin
         if (!in_req) begin
            in_req = 1;
            rlen   = 0;
            if (req_q.size() == 0) begin
               checks++; errors++;
               cur.len = -1;
               $display("FAIL unexpected_req: got req addr %h expected none", o_mem_addr);
            end else begin
               cur = req_q.pop_front();
               chk("req_we",    {31'b0, o_mem_we}, {31'b0, cur.we});
               chk("req_addr",  o_mem_addr,  cur.addr);
               chk("req_wdata", o_mem_wdata, cur.wdata);
               chk("req_bmask", {28'b0, o_mem_bmask}, {28'b0, cur.bmask});
            end
         end
         rlen++;
      end else if (in_req) begin
         in_req = 0;
         if (cur.len >= 0) chk("req_len", rlen, cur.len);
      end
      if (o_lsu_done) begin
         if (rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done expected none");
         end else begin
            r = rsp_q.pop_front();
            if (r.chk_ld) chk("ld_data", o_ld_data, r.ld);
            chk("misalign",  {31'b0, o_misalign}, {31'b0, r.mis});
            chk("bus_err",   {31'b0, o_bus_err},  {31'b0, r.berr});
            chk("insn_vld",  {31'b0, o_insn_vld}, {31'b0, r.ivld});
            chk("done_cycle", cyc, r.done_cyc);
         end
      end
   end

   // lat: cycles from vld (cycle 1) to the done cycle; inj: REQ cycle on which to pulse a stray vld.
   task automatic access(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] st, input logic [31:0] rd, input int ack_wait,
                         input int lat, input bit exp_req, input logic [3:0] bm,
                         input logic [31:0] wd, input int len, input logic [31:0] ld,
                         input bit chk_ld, input logic mis, input logic berr,
                         input logic ivld, input int inj);
      int rc;
      int n;
      if (exp_req) req_q.push_back('{wren, {addr[31:2], 2'b00}, wd, bm, len});
      rsp_q.push_back('{ld, chk_ld, mis, berr, ivld, cyc + lat});
      i_lsu_vld = 1; i_lsu_wren = wren; i_funct3 = f3; i_addr = addr; i_st_data = st;
      @(posedge clk); #1;
      i_lsu_vld = 0; i_addr = 32'hFFFF_FFFF; i_funct3 = LSU_W; i_lsu_wren = 1'b0;
      rc = 0; n = 0;
      while (!o_lsu_done && n < 64) begin
         i_mem_ack   = o_mem_req && (ack_wait >= 0) && (rc == ack_wait);
         i_mem_rdata = i_mem_ack ? rd : 32'h5A5A_5A5A;
         i_lsu_vld   = o_mem_req && (rc == inj);
         i_addr      = i_lsu_vld ? 32'h0000_0300 : 32'hFFFF_FFFF;
         if (o_mem_req) rc++;
         @(posedge clk); #1;
         n++;
      end
      i_mem_ack = 0; i_lsu_vld = 0;
      if (n >= 64) begin
         checks++; errors++;
         $display("FAIL done_wait: got no done after %0d cycles expected done", n);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 0; i_lsu_vld = 0; i_lsu_wren = 0; i_funct3 = 3'b000;
      i_addr = 0; i_st_data = 0; i_mem_ack = 0; i_mem_rdata = 0;
      #12;
      chk("rst_req",   {31'b0, o_mem_req},  32'h0);
      chk("rst_busy",  {31'b0, o_lsu_busy}, 32'h0);
      chk("rst_done",  {31'b0, o_lsu_done}, 32'h0);
      chk("rst_ld",    o_ld_data,           32'h0);
      chk("rst_bmask", {28'b0, o_mem_bmask}, 32'h0);
      chk("rst_ivld",  {31'b0, o_insn_vld}, 32'h0);
      @(negedge clk); i_rst_n = 1;
      @(posedge clk); #1;

      // LW, zero-wait ack
      access(0, LSU_W, 32'h100, 32'h1122_3344, 32'hDEAD_BEEF, 0, 3, 1, 4'b1111,
             32'h1122_3344, 1, 32'hDEAD_BEEF, 1, 0, 0, 1, -1);
      chk("ld_hold",   o_ld_data, 32'hDEAD_BEEF);
      chk("idle_done", {31'b0, o_lsu_done}, 32'h0);
      // LB / LBU at top byte
      access(0, LSU_B,  32'h103, 32'h0, 32'h80FF_0000, 0, 3, 1, 4'b1000,
             32'h0, 1, 32'hFFFF_FF80, 1, 0, 0, 1, -1);
      access(0, LSU_BU, 32'h103, 32'h0, 32'h80FF_0000, 0, 3, 1, 4'b1000,
             32'h0, 1, 32'h0000_0080, 1, 0, 0, 1, -1);
      // SH upper half, two wait cycles, read data must not leak
      access(1, LSU_H, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 2, 5, 1, 4'b1100,
             32'hABCD_ABCD, 3, 32'h0, 1, 0, 0, 1, -1);
      // LW misaligned: no request
      access(0, LSU_W, 32'h101, 32'h0, 32'h0, 0, 2, 0, 4'b0000,
             32'h0, 0, 32'h0, 0, 1, 0, 1, -1);
      // SW never acked, stray vld mid-request
      access(1, LSU_W, 32'h0, 32'hCAFE_F00D, 32'h0, -1, TO + 2, 1, 4'b1111,
             32'hCAFE_F00D, TO, 32'h0, 1, 0, 1, 1, 3);
      chk("berr_clr", {31'b0, o_bus_err}, 32'h0);
      // Ack on the last allowed cycle is success
      access(0, LSU_W, 32'h10, 32'h0, 32'h1357_9BDF, TO - 1, TO + 2, 1, 4'b1111,
             32'h0, TO, 32'h1357_9BDF, 1, 0, 0, 1, -1);
      // LH / LHU
      access(0, LSU_H,  32'h102, 32'h0, 32'h8001_7FFF, 0, 3, 1, 4'b1100,
             32'h0, 1, 32'hFFFF_8001, 1, 0, 0, 1, -1);
      access(0, LSU_HU, 32'h100, 32'h0, 32'h8001_8002, 1, 4, 1, 4'b0011,
             32'h0, 2, 32'h0000_8002, 1, 0, 0, 1, -1);
      // SB lane 1
      access(1, LSU_B, 32'h001, 32'h0000_00A5, 32'h0, 0, 3, 1, 4'b0010,
             32'hA5A5_A5A5, 1, 32'h0, 1, 0, 0, 1, -1);
      // Illegal: unsigned store, reserved funct3 load
      access(1, LSU_BU, 32'h0, 32'h0, 32'h0, 0, 2, 0, 4'b0000,
             32'h0, 0, 32'h0, 0, 0, 0, 0, -1);
      access(0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 2, 0, 4'b0000,
             32'h0, 0, 32'h0, 0, 0, 0, 0, -1);
      // SH misaligned
      access(1, LSU_H, 32'h203, 32'h0, 32'h0, 0, 2, 0, 4'b0000,
             32'h0, 0, 32'h0, 0, 1, 0, 1, -1);

      // Reset in the middle of a request
      req_q.push_back('{1'b0, 32'h40, 32'h0, 4'b1111, -1});
      i_lsu_vld = 1; i_lsu_wren = 0; i_funct3 = LSU_W; i_addr = 32'h40; i_st_data = 0;
      @(posedge clk); #1;
      i_lsu_vld = 0;
      @(negedge clk); #1;
      i_rst_n = 0;
      #1;
      chk("arst_req",  {31'b0, o_mem_req},  32'h0);
      chk("arst_busy", {31'b0, o_lsu_busy}, 32'h0);
      @(negedge clk); #1;
      i_rst_n = 1;
      @(posedge clk); #1;
      access(0, LSU_W, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 3, 1, 4'b1111,
             32'h0, 1, 32'h0BAD_F00D, 1, 0, 0, 1, -1);

      repeat (2) @(posedge clk);
      chk("req_q_left", req_q.size(), 32'h0);
      chk("rsp_q_left", rsp_q.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
